// File: rtl/mem_read_seq.sv
// Read-side sequencer for the capture RAM.
// Walks addresses 0..LAST_ADDR of a 1-cycle-latency synchronous RAM and
// streams every word out over valid/ready through a 2-entry FIFO, then
// pulses done and holds until the run enable is released.
module mem_read_seq #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 12282
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t            state, state_nxt;

    // Stage p0: next address to issue. Stage p1: read in flight to the RAM.
    logic [ADDR_W-1:0] addr_p0;
    logic              vld_p1;

    // Stage p2: 2-entry FIFO between RAM read data and the stream.
    logic [DATA_W-1:0] fifo_mem_p2 [2];
    logic              wr_ptr_p2;
    logic              rd_ptr_p2;
    logic [1:0]        fifo_cnt_p2;

    logic              push;
    logic              pop;
    logic              flush;
    logic [1:0]        credit_used;

    assign out_valid = (fifo_cnt_p2 != 2'd0);
    // Head is masked while empty so the stream shows 0 after reset/abort.
    assign out_data  = out_valid ? fifo_mem_p2[rd_ptr_p2] : '0;
    assign mem_addr  = addr_p0;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign push      = vld_p1;
    assign flush     = busy && !st;

    // Next-state, read issue and completion decode.
    always_comb begin
        state_nxt   = state;
        mem_en      = 1'b0;
        done        = 1'b0;
        pop         = out_valid && out_ready;
        // A word leaving this cycle frees its slot in time for the read
        // issued now, which is what allows one word per cycle with ready=1.
        credit_used = fifo_cnt_p2 - {1'b0, pop} + {1'b0, vld_p1};
        case (state)
            IDLE: begin
                if (st) state_nxt = RUN;
            end
            RUN: begin
                mem_en = (credit_used < 2'd2);
                if (!st)
                    state_nxt = IDLE;
                else if (mem_en && (addr_p0 == LAST))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!st) begin
                    state_nxt = IDLE;
                end else if (pop && (fifo_cnt_p2 == 2'd1) && !vld_p1) begin
                    done      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!st) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Address counter, in-flight flag and FIFO bookkeeping; abort clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p0     <= '0;
            vld_p1      <= 1'b0;
            wr_ptr_p2   <= 1'b0;
            rd_ptr_p2   <= 1'b0;
            fifo_cnt_p2 <= 2'd0;
        end else if (flush) begin
            addr_p0     <= '0;
            vld_p1      <= 1'b0;
            wr_ptr_p2   <= 1'b0;
            rd_ptr_p2   <= 1'b0;
            fifo_cnt_p2 <= 2'd0;
        end else begin
            vld_p1 <= mem_en;
            if (state == IDLE)
                addr_p0 <= '0;
            else if (mem_en && (addr_p0 != LAST))
                addr_p0 <= addr_p0 + ADDR_W'(1);
            if (push) wr_ptr_p2 <= ~wr_ptr_p2;
            if (pop)  rd_ptr_p2 <= ~rd_ptr_p2;
            fifo_cnt_p2 <= fifo_cnt_p2 + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage captures RAM data the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_p2[wr_ptr_p2] <= mem_data;
    end

endmodule

// File: tb/tb_mem_read_seq.sv
// Directed self-checking bench for mem_read_seq: a short instance
// (LAST_ADDR=7) for the scenarios and a default-size instance for a full run.
module tb_mem_read_seq;

    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int BIG_LAST = 12282;

    logic          clk;
    logic          rst;
    logic          st, out_ready, mem_en, out_valid, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, out_data;
    logic          st_b, ready_b, mem_en_b, out_valid_b, busy_b, done_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_data_b, out_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    mem_read_seq #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(7)) dut (
        .clk(clk), .rst(rst), .st(st), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    mem_read_seq #(.ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk(clk), .rst(rst), .st(st_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
        .mem_data(mem_data_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(ready_b), .busy(busy_b), .done(done_b)
    );

    // RAM contents: a fixed byte pattern of the address.
    function automatic logic [DW-1:0] ram_f(input int a);
        int t;
        t = (a * 37 + 11) % 256;
        return DW'(t);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en)   mem_data   <= ram_f(int'(mem_addr));
        if (mem_en_b) mem_data_b <= ram_f(int'(mem_addr_b));
    end

    task automatic go_idle();
        st = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; st = 1'b0; out_ready = 1'b0; st_b = 1'b0; ready_b = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (mem_en !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_checks++; if (mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b mem_en %b want 0 0", busy, mem_en); end
    endtask

    // Full run with ready held high: fixed timing from the IDLE->RUN edge.
    task automatic test_basic();
        int iss, acc, dn, first_v;
        iss = 0; acc = 0; dn = 0; first_v = -1;
        @(negedge clk);
        st = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk); #1;
            if (mem_en === 1'b1) begin
                n_checks++;
                if (mem_addr !== AW'(iss) || c != iss + 1) begin
                    n_fail++; $display("FAIL basic_addr: cycle %0d got addr %0d want addr %0d at cycle %0d", c, mem_addr, iss, iss + 1);
                end
                iss++;
            end
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                n_checks++;
                if (out_data !== ram_f(acc) || c != acc + 3) begin
                    n_fail++; $display("FAIL basic_data: cycle %0d got %0d want %0d (word %0d)", c, out_data, ram_f(acc), acc);
                end
                acc++;
            end
            if (done === 1'b1) begin
                dn++;
                n_checks++; if (acc != 8) begin n_fail++; $display("FAIL basic_done_word: done with %0d words want 8", acc); end
            end
            if (c == 11) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_done: got %b want 0", busy); end
            end
        end
        n_checks++; if (iss != 8)     begin n_fail++; $display("FAIL basic_reads: got %0d want 8", iss); end
        n_checks++; if (acc != 8)     begin n_fail++; $display("FAIL basic_words: got %0d want 8", acc); end
        n_checks++; if (dn != 1)      begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", dn); end
        n_checks++; if (first_v != 3) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 3", first_v); end
        go_idle();
    endtask

    // Ready pattern 1,0,0 repeating; occupancy tracked by a reference model.
    task automatic test_backpressure();
        int iss, acc, dn, occ, infl;
        logic pv, pr;
        logic [DW-1:0] pd;
        iss = 0; acc = 0; dn = 0; occ = 0; infl = 0; pv = 1'b0; pr = 1'b0; pd = '0;
        @(negedge clk);
        st = 1'b1; out_ready = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            out_ready = ((c - 1) % 3 == 0);
            #1;
            n_checks++;
            if (out_valid !== (occ > 0)) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %b want %0d", c, out_valid, occ > 0); end
            if (pv && !pr) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== pd) begin
                    n_fail++; $display("FAIL bp_stable: cycle %0d got %b/%0d want 1/%0d", c, out_valid, out_data, pd);
                end
            end
            if (mem_en === 1'b1) begin
                if (!out_ready) begin
                    n_checks++;
                    if (occ + infl >= 2) begin n_fail++; $display("FAIL bp_credit: cycle %0d read with fifo+inflight %0d want <2", c, occ + infl); end
                end
                n_checks++;
                if (mem_addr !== AW'(iss)) begin n_fail++; $display("FAIL bp_addr: got %0d want %0d", mem_addr, iss); end
                iss++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (out_data !== ram_f(acc)) begin n_fail++; $display("FAIL bp_data: got %0d want %0d (word %0d)", out_data, ram_f(acc), acc); end
                acc++;
            end
            if (done === 1'b1) dn++;
            occ  = occ - ((out_valid === 1'b1 && out_ready) ? 1 : 0) + infl;
            infl = (mem_en === 1'b1) ? 1 : 0;
            pv = out_valid; pr = out_ready; pd = out_data;
        end
        n_checks++; if (iss != 8) begin n_fail++; $display("FAIL bp_reads: got %0d want 8", iss); end
        n_checks++; if (acc != 8) begin n_fail++; $display("FAIL bp_words: got %0d want 8", acc); end
        n_checks++; if (dn != 1)  begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", dn); end
        go_idle();
    endtask

    // Consumer stalled from the start: two reads only, then resume from 2.
    task automatic test_stall();
        int iss, acc, dn, resume;
        iss = 0; acc = 0; dn = 0; resume = -1;
        @(negedge clk);
        st = 1'b1; out_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            if (mem_en === 1'b1) begin
                n_checks++;
                if (mem_addr !== AW'(iss)) begin n_fail++; $display("FAIL stall_addr: got %0d want %0d", mem_addr, iss); end
                iss++;
            end
        end
        n_checks++; if (iss != 2) begin n_fail++; $display("FAIL stall_reads: got %0d want 2", iss); end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== ram_f(0)) begin
            n_fail++; $display("FAIL stall_head: got %b/%0d want 1/%0d", out_valid, out_data, ram_f(0));
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (mem_en === 1'b1) begin
                if (resume < 0) resume = int'(mem_addr);
                n_checks++;
                if (mem_addr !== AW'(iss)) begin n_fail++; $display("FAIL stall_addr2: got %0d want %0d", mem_addr, iss); end
                iss++;
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_data !== ram_f(acc)) begin n_fail++; $display("FAIL stall_data: got %0d want %0d", out_data, ram_f(acc)); end
                acc++;
            end
            if (done === 1'b1) dn++;
        end
        n_checks++; if (resume != 2) begin n_fail++; $display("FAIL stall_resume: got %0d want 2", resume); end
        n_checks++; if (acc != 8)    begin n_fail++; $display("FAIL stall_words: got %0d want 8", acc); end
        n_checks++; if (dn != 1)     begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", dn); end
        go_idle();
    endtask

    // st dropped after three accepted words; restart begins at address 0.
    task automatic test_abort();
        int acc, dn;
        acc = 0; dn = 0;
        @(negedge clk);
        st = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 20 && acc < 3; c++) begin
            @(negedge clk); #1;
            if (out_valid === 1'b1) acc++;
            if (done === 1'b1) dn++;
        end
        n_checks++; if (acc != 3) begin n_fail++; $display("FAIL abort_timeout: got %0d words want 3", acc); end
        @(negedge clk);
        st = 1'b0;
        #1;
        if (done === 1'b1) dn++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== ram_f(3)) begin
            n_fail++; $display("FAIL abort_last_word: got %b/%0d want 1/%0d", out_valid, out_data, ram_f(3));
        end
        @(negedge clk); #1;
        if (done === 1'b1) dn++;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        n_checks++; if (mem_en !== 1'b0)    begin n_fail++; $display("FAIL abort_mem_en: got %b want 0", mem_en); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (dn != 0)            begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", dn); end
        @(negedge clk);
        st = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== '0) begin
            n_fail++; $display("FAIL abort_restart: got en %b addr %0d want en 1 addr 0", mem_en, mem_addr);
        end
        go_idle();
    endtask

    // Asynchronous reset while draining clears every output before an edge.
    task automatic test_rst_drain();
        int found;
        found = 0;
        @(negedge clk);
        st = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk); #1;
            if (mem_en === 1'b1 && mem_addr === AW'(7)) found = 1;
        end
        n_checks++; if (found != 1) begin n_fail++; $display("FAIL rst_last_addr_timeout: got %0d want 1", found); end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || mem_en !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_drain: busy %b mem_en %b valid %b want 1 0 1", busy, mem_en, out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL rst_async_data: got %0d want 0", out_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        n_checks++; if (mem_addr !== '0)    begin n_fail++; $display("FAIL rst_async_addr: got %0d want 0", mem_addr); end
        n_checks++;
        if (mem_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_async_en_done: got %b %b want 0 0", mem_en, done); end
        st = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Default-size run on the second instance.
    task automatic test_default_size();
        int iss, acc, dn, bad_addr, bad_data, last_a, stop_at;
        iss = 0; acc = 0; dn = 0; bad_addr = 0; bad_data = 0; last_a = -1; stop_at = 13000;
        @(negedge clk);
        st_b = 1'b1; ready_b = 1'b1;
        for (int c = 1; c <= stop_at; c++) begin
            @(negedge clk); #1;
            if (mem_en_b === 1'b1) begin
                if (mem_addr_b !== AW'(iss)) begin
                    if (bad_addr == 0) $display("first bad address: got %0d want %0d", mem_addr_b, iss);
                    bad_addr++;
                end
                last_a = int'(mem_addr_b);
                iss++;
            end
            if (out_valid_b === 1'b1) begin
                if (out_data_b !== ram_f(acc)) begin
                    if (bad_data == 0) $display("first bad word %0d: got %0d want %0d", acc, out_data_b, ram_f(acc));
                    bad_data++;
                end
                acc++;
            end
            if (done_b === 1'b1) begin
                dn++;
                if (stop_at > c + 10) stop_at = c + 10;
            end
        end
        n_checks++; if (bad_addr != 0)       begin n_fail++; $display("FAIL big_addr_order: got %0d bad want 0", bad_addr); end
        n_checks++; if (bad_data != 0)       begin n_fail++; $display("FAIL big_data_order: got %0d bad want 0", bad_data); end
        n_checks++; if (acc != BIG_LAST + 1) begin n_fail++; $display("FAIL big_words: got %0d want %0d", acc, BIG_LAST + 1); end
        n_checks++; if (iss != BIG_LAST + 1) begin n_fail++; $display("FAIL big_reads: got %0d want %0d", iss, BIG_LAST + 1); end
        n_checks++; if (last_a != BIG_LAST)  begin n_fail++; $display("FAIL big_last_addr: got %0d want %0d", last_a, BIG_LAST); end
        n_checks++; if (dn != 1)             begin n_fail++; $display("FAIL big_done_count: got %0d want 1", dn); end
        st_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_abort();
        test_basic();
        test_rst_drain();
        test_basic();
        test_default_size();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
